tag_checker: RTL

Consumer side of the DRAM-cache tag lookup path. Pops request entries `{wr, tid, addr}` from the tag FIFO and accepts the tag-read response on the AXI R channel from the memory controller. Compares the stored tag against the request address and emits one hit/miss result per request to the downstream data-path controller. Responses arrive in issue order on a single AXI ID, so FIFO entry N always pairs with R response N.

---
 rtl/tag_checker_pkg.sv | 69 ++++++
 rtl/tag_checker_compare.sv | 41 ++++
 rtl/tag_checker.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tag_checker_pkg.sv
// Shared definitions for the DRAM-cache tag lookup path: default widths,
// tag-FIFO entry layout, tag-word bit positions, AXI response codes and
// the tag_checker FSM encoding.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 512
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 20
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 6
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 8
`endif

package tag_checker_pkg;

    // Tag width for the default build; parameterised users call calc_tag_width.
    localparam int TAG_WIDTH = `AXI_ADDR_WIDTH - `INDEX_WIDTH - `OFFSET_WIDTH;

    // AXI response code for a successful read.
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // tag_checker FSM encoding.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT_R = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

    // Saturation value of the statistics counters.
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Address bits left over for the tag once index and offset are removed.
    function automatic int calc_tag_width(input int addr_w, input int index_w,
                                          input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    // Tag word layout: {dirty, valid, stored_tag}.
    function automatic int valid_bit(input int tag_w);
        return tag_w;
    endfunction

    function automatic int dirty_bit(input int tag_w);
        return tag_w + 1;
    endfunction

    // Tag-FIFO entry layout: {wr, tid, addr}, addr in the low bits.
    function automatic int entry_addr_lsb();
        return 0;
    endfunction

    function automatic int entry_tid_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int entry_wr_bit(input int addr_w, input int tid_w);
        return addr_w + tid_w;
    endfunction

endpackage

// File: rtl/tag_checker_compare.sv
// tag_compare: purely combinational tag match for one request address
// against one stored tag word. Shared between the lookup and fill paths,
// so it knows nothing about AXI response codes.

module tag_compare
    import tag_checker_pkg::*;
#(
    parameter int ADDR_WIDTH   = `AXI_ADDR_WIDTH,
    parameter int INDEX_WIDTH  = `INDEX_WIDTH,
    parameter int OFFSET_WIDTH = `OFFSET_WIDTH,
    localparam int TAG_W       = calc_tag_width(ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH)
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [TAG_W+1:0]      tag_word_i,
    output logic                  hit_o,
    output logic                  dirty_o,
    output logic [ADDR_WIDTH-1:0] victim_addr_o
);

    localparam int VALID_B = valid_bit(TAG_W);
    localparam int DIRTY_B = dirty_bit(TAG_W);

    logic [TAG_W-1:0]       req_tag_s;
    logic [TAG_W-1:0]       stored_tag_s;
    logic [INDEX_WIDTH-1:0] req_index_s;
    logic                   unused_offset_s;

    assign req_tag_s    = addr_i[ADDR_WIDTH-1 -: TAG_W];
    assign req_index_s  = addr_i[OFFSET_WIDTH +: INDEX_WIDTH];
    assign stored_tag_s = tag_word_i[TAG_W-1:0];

    assign hit_o         = tag_word_i[VALID_B] && (stored_tag_s == req_tag_s);
    assign dirty_o       = tag_word_i[DIRTY_B];
    // The line that would be evicted lives in the same set, so it keeps the
    // request index and takes the stored tag.
    assign victim_addr_o = {stored_tag_s, req_index_s, {OFFSET_WIDTH{1'b0}}};

    // Line-offset bits play no part in a tag lookup.
    assign unused_offset_s = ^addr_i[OFFSET_WIDTH-1:0];

endmodule

// File: rtl/tag_checker.sv
// tag_checker: pops one request from the FWFT tag FIFO, takes the in-order
// tag-read response from the AXI R channel (tag from the first beat only,
// remaining beats drained), and presents one hit/miss result downstream.
// Optional build macro: TAG_CHECK_STAT_EN adds saturating hit/miss counters.

module tag_checker
    import tag_checker_pkg::*;
#(
    parameter int ADDR_WIDTH   = `AXI_ADDR_WIDTH,
    parameter int ID_WIDTH     = `AXI_ID_WIDTH,
    parameter int DATA_WIDTH   = `AXI_DATA_WIDTH,
    parameter int INDEX_WIDTH  = `INDEX_WIDTH,
    parameter int OFFSET_WIDTH = `OFFSET_WIDTH,
    parameter int TID_WIDTH    = `TID_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tag_fifo_empty_i,
    output logic                            tag_fifo_rden_o,
    input  logic [ADDR_WIDTH+TID_WIDTH:0]   tag_fifo_data_i,
    input  logic [ID_WIDTH-1:0]             rid_i,
    input  logic [DATA_WIDTH-1:0]           rdata_i,
    input  logic [1:0]                      rresp_i,
    input  logic                            rlast_i,
    input  logic                            rvalid_i,
    output logic                            rready_o,
    output logic                            result_valid_o,
    input  logic                            result_ready_i,
    output logic                            result_hit_o,
    output logic                            result_dirty_o,
    output logic                            result_err_o,
    output logic                            result_wr_o,
    output logic [TID_WIDTH-1:0]            result_tid_o,
    output logic [ADDR_WIDTH-1:0]           result_addr_o,
    output logic [ADDR_WIDTH-1:0]           result_victim_addr_o
`ifdef TAG_CHECK_STAT_EN
    ,
    output logic [31:0]                     hit_cnt_o,
    output logic [31:0]                     miss_cnt_o
`endif
);

    localparam int TAG_W    = calc_tag_width(ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH);
    localparam int WR_B     = entry_wr_bit(ADDR_WIDTH, TID_WIDTH);
    localparam int TID_LSB  = entry_tid_lsb(ADDR_WIDTH);
    localparam int ADDR_LSB = entry_addr_lsb();

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  pop_s;
    logic                  rready_s;
    logic                  r_acc_s;
    logic                  first_beat_s;

    logic                  entry_wr_q;
    logic [TID_WIDTH-1:0]  entry_tid_q;
    logic [ADDR_WIDTH-1:0] entry_addr_q;

    logic                  res_valid_q;
    logic                  res_hit_q;
    logic                  res_dirty_q;
    logic                  res_err_q;
    logic                  res_wr_q;
    logic [TID_WIDTH-1:0]  res_tid_q;
    logic [ADDR_WIDTH-1:0] res_addr_q;
    logic [ADDR_WIDTH-1:0] res_victim_q;

    logic                  cmp_hit_s;
    logic                  cmp_dirty_s;
    logic [ADDR_WIDTH-1:0] cmp_victim_s;
    logic                  resp_ok_s;
    logic                  unused_s;

    tag_compare #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .INDEX_WIDTH  (INDEX_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_tag_compare (
        .addr_i        (entry_addr_q),
        .tag_word_i    (rdata_i[TAG_W+1:0]),
        .hit_o         (cmp_hit_s),
        .dirty_o       (cmp_dirty_s),
        .victim_addr_o (cmp_victim_s)
    );

    assign resp_ok_s    = (rresp_i == RESP_OKAY);
    assign r_acc_s      = rready_s && rvalid_i;
    assign first_beat_s = (state_q == S_WAIT_R) && r_acc_s;

    // Handshake strobes decode straight from the state; both are held low
    // while reset is asserted so nothing is popped or accepted into a
    // machine that is about to be cleared.
    always_comb begin
        pop_s    = 1'b0;
        rready_s = 1'b0;
        case (state_q)
            S_IDLE:   pop_s    = !tag_fifo_empty_i && rst_n;
            S_WAIT_R: rready_s = rst_n;
            S_DRAIN:  rready_s = rst_n;
            S_OUT:    rready_s = 1'b0;
            default: begin
                pop_s    = 1'b0;
                rready_s = 1'b0;
            end
        endcase
    end

    // Next-state logic: one request at a time, pop -> tag beat -> drain -> result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop_s) state_d = S_WAIT_R;
                else       state_d = S_IDLE;
            end
            S_WAIT_R: begin
                if (r_acc_s) state_d = rlast_i ? S_OUT : S_DRAIN;
                else         state_d = S_WAIT_R;
            end
            S_DRAIN: begin
                if (r_acc_s && rlast_i) state_d = S_OUT;
                else                    state_d = S_DRAIN;
            end
            S_OUT: begin
                if (result_ready_i) state_d = S_IDLE;
                else                state_d = S_OUT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and the registered result-valid flag tracking it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= (state_d == S_OUT);
        end
    end

    // Hold the popped request until its tag beat arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_wr_q   <= 1'b0;
            entry_tid_q  <= '0;
            entry_addr_q <= '0;
        end else if (pop_s) begin
            entry_wr_q   <= tag_fifo_data_i[WR_B];
            entry_tid_q  <= tag_fifo_data_i[TID_LSB +: TID_WIDTH];
            entry_addr_q <= tag_fifo_data_i[ADDR_LSB +: ADDR_WIDTH];
        end else begin
            entry_wr_q   <= entry_wr_q;
            entry_tid_q  <= entry_tid_q;
            entry_addr_q <= entry_addr_q;
        end
    end

    // Result fields load only on the first R beat and stay put through
    // draining and the output handshake; an error response can never hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_hit_q    <= 1'b0;
            res_dirty_q  <= 1'b0;
            res_err_q    <= 1'b0;
            res_wr_q     <= 1'b0;
            res_tid_q    <= '0;
            res_addr_q   <= '0;
            res_victim_q <= '0;
        end else if (first_beat_s) begin
            res_hit_q    <= cmp_hit_s && resp_ok_s;
            res_dirty_q  <= cmp_dirty_s;
            res_err_q    <= !resp_ok_s;
            res_wr_q     <= entry_wr_q;
            res_tid_q    <= entry_tid_q;
            res_addr_q   <= entry_addr_q;
            res_victim_q <= cmp_victim_s;
        end else begin
            res_hit_q    <= res_hit_q;
            res_dirty_q  <= res_dirty_q;
            res_err_q    <= res_err_q;
            res_wr_q     <= res_wr_q;
            res_tid_q    <= res_tid_q;
            res_addr_q   <= res_addr_q;
            res_victim_q <= res_victim_q;
        end
    end

    assign tag_fifo_rden_o      = pop_s;
    assign rready_o             = rready_s;
    assign result_valid_o       = res_valid_q;
    assign result_hit_o         = res_hit_q;
    assign result_dirty_o       = res_dirty_q;
    assign result_err_o         = res_err_q;
    assign result_wr_o          = res_wr_q;
    assign result_tid_o         = res_tid_q;
    assign result_addr_o        = res_addr_q;
    assign result_victim_addr_o = res_victim_q;

`ifdef TAG_CHECK_STAT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        res_fire_s;

    assign res_fire_s = res_valid_q && result_ready_i;

    // Saturating hit/miss counters, bumped once per delivered result;
    // errored results are misses because their hit flag is forced low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (res_fire_s) begin
            if (res_hit_q) begin
                hit_cnt_q  <= (hit_cnt_q == CNT_MAX) ? hit_cnt_q : hit_cnt_q + 32'd1;
                miss_cnt_q <= miss_cnt_q;
            end else begin
                hit_cnt_q  <= hit_cnt_q;
                miss_cnt_q <= (miss_cnt_q == CNT_MAX) ? miss_cnt_q : miss_cnt_q + 32'd1;
            end
        end else begin
            hit_cnt_q  <= hit_cnt_q;
            miss_cnt_q <= miss_cnt_q;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

    // The single AXI ID and the data above the tag word carry nothing here.
    assign unused_s = ^{rid_i, rdata_i[DATA_WIDTH-1:TAG_W+2]};

endmodule
